// File: rtl/shift_result_stage_pkg.sv
// Shared definitions for the shift result stage: opcode values, skid-buffer
// state encoding, error counter width and the per-entry flag bundle.
package shift_result_stage_pkg;

  // Shift opcodes carried on in_h
  localparam logic [1:0] OP_PASS    = 2'b00;
  localparam logic [1:0] OP_LEFT    = 2'b01;
  localparam logic [1:0] OP_RIGHT   = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  // Occupancy of the two-entry skid buffer
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // Illegal-opcode counter width and its saturation value
  localparam int ERR_COUNT_W = 8;
  localparam logic [ERR_COUNT_W-1:0] ERR_COUNT_MAX = '1;

  // Flags stored alongside each buffered result
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic err;
  } flags_t;

endpackage

// File: rtl/shift_result_stage_flags.sv
// Combinational flag generation for one shifter result. Illegal opcodes
// force the result to zero so nothing undefined ever reaches the buffer.
module shift_flags
  import shift_result_stage_pkg::*;
#(
  parameter int word_Size = 32
) (
  input  logic [1:0]           h,
  input  logic [word_Size-1:0] b,
  input  logic [4:0]           sh,
  input  logic [word_Size-1:0] result,
  output logic [word_Size-1:0] result_out,
  output flags_t               flags
);

  logic [4:0] left_idx;
  logic [4:0] right_idx;

  // Bit positions that fall off the operand edge for a nonzero shift amount
  always_comb begin
    left_idx  = 5'(word_Size - int'(sh));
    right_idx = sh - 5'd1;
  end

  // Sanitise the result, then derive carry, error, zero and negative flags
  always_comb begin
    result_out = result;
    flags      = '0;
    case (h)
      OP_LEFT: begin
        if (sh != 5'd0) flags.c = b[left_idx];
      end
      OP_RIGHT: begin
        if (sh != 5'd0) flags.c = b[right_idx];
      end
      OP_ILLEGAL: begin
        result_out = '0;
        flags.err  = 1'b1;
      end
      default: begin
      end
    endcase
    flags.z = (result_out == '0);
    flags.n = result_out[word_Size-1];
  end

endmodule

// File: rtl/shift_result_stage.sv
// Result stage behind the shifter: flags are computed at acceptance and the
// result plus flags are held in a two-entry skid buffer. in_ready is a
// registered signal, so upstream never sees a combinational path from
// out_ready.
module shift_result_stage
  import shift_result_stage_pkg::*;
#(
  parameter int word_Size = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_h,
  input  logic [word_Size-1:0]   in_b,
  input  logic [4:0]             in_sh,
  input  logic [word_Size-1:0]   in_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [word_Size-1:0]   out_result,
  output logic                   out_z,
  output logic                   out_n,
  output logic                   out_c,
  output logic                   out_err,
  output logic [ERR_COUNT_W-1:0] err_count
);

  skid_state_e            state_q, state_d;
  logic                   in_ready_q, in_ready_d;
  logic [word_Size-1:0]   head_result_q, head_result_d;
  flags_t                 head_flags_q, head_flags_d;
  logic [word_Size-1:0]   tail_result_q, tail_result_d;
  flags_t                 tail_flags_q, tail_flags_d;
  logic [ERR_COUNT_W-1:0] err_count_q, err_count_d;

  logic [word_Size-1:0]   new_result;
  flags_t                 new_flags;
  logic                   accept;
  logic                   pop;

  shift_flags #(
    .word_Size (word_Size)
  ) u_flags (
    .h          (in_h),
    .b          (in_b),
    .sh         (in_sh),
    .result     (in_result),
    .result_out (new_result),
    .flags      (new_flags)
  );

  // Handshake qualifiers; in_ready_q is already low in FULL so in_valid is ignored there
  always_comb begin
    out_valid = (state_q != SKID_EMPTY);
    accept    = in_valid & in_ready_q;
    pop       = out_valid & out_ready;
  end

  // Buffer control: the head register always drives the outputs, the tail only holds overflow
  always_comb begin
    state_d       = state_q;
    head_result_d = head_result_q;
    head_flags_d  = head_flags_q;
    tail_result_d = tail_result_q;
    tail_flags_d  = tail_flags_q;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          head_result_d = new_result;
          head_flags_d  = new_flags;
          state_d       = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (accept && pop) begin
          head_result_d = new_result;
          head_flags_d  = new_flags;
        end else if (accept) begin
          tail_result_d = new_result;
          tail_flags_d  = new_flags;
          state_d       = SKID_FULL;
        end else if (pop) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (pop) begin
          head_result_d = tail_result_q;
          head_flags_d  = tail_flags_q;
          state_d       = SKID_ONE;
        end
      end
      default: begin
        state_d = SKID_EMPTY;
      end
    endcase
    in_ready_d = (state_d != SKID_FULL);
  end

  // Illegal entries are counted when accepted, saturating at the top value
  always_comb begin
    err_count_d = err_count_q;
    if (accept && new_flags.err && (err_count_q != ERR_COUNT_MAX)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  // State registers; reset discards all entries and holds in_ready low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SKID_EMPTY;
      in_ready_q    <= 1'b0;
      head_result_q <= '0;
      head_flags_q  <= '0;
      tail_result_q <= '0;
      tail_flags_q  <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      head_result_q <= head_result_d;
      head_flags_q  <= head_flags_d;
      tail_result_q <= tail_result_d;
      tail_flags_q  <= tail_flags_d;
      err_count_q   <= err_count_d;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    in_ready   = in_ready_q;
    out_result = head_result_q;
    out_z      = head_flags_q.z;
    out_n      = head_flags_q.n;
    out_c      = head_flags_q.c;
    out_err    = head_flags_q.err;
    err_count  = err_count_q;
  end

endmodule

// File: tb/tb_shift_result_stage.sv
// Self-checking bench for shift_result_stage: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_shift_result_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_h;
  logic [31:0] in_b;
  logic [4:0]  in_sh;
  logic [31:0] in_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_z;
  logic        out_n;
  logic        out_c;
  logic        out_err;
  logic [7:0]  err_count;

  typedef struct {
    logic [31:0] result;
    logic        z;
    logic        n;
    logic        c;
    logic        err;
  } entry_t;

  entry_t      modelQ[$];
  bit          modelReady;
  int          modelErr;
  int          nAsserts;
  int          nFail;
  logic [31:0] prevResult;

  shift_result_stage #(
    .word_Size (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_h       (in_h),
    .in_b       (in_b),
    .in_sh      (in_sh),
    .in_result  (in_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_z      (out_z),
    .out_n      (out_n),
    .out_c      (out_c),
    .out_err    (out_err),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: what a shift of B by SH produces and which bit falls off the end
  function automatic entry_t refEntry(input logic [1:0] h, input logic [31:0] b, input logic [4:0] sh);
    entry_t      e;
    logic [32:0] wide;
    e.result = 32'd0;
    e.c      = 1'b0;
    e.err    = 1'b0;
    case (h)
      2'd0: e.result = b;
      2'd1: begin
        wide     = {1'b0, b} << sh;
        e.result = wide[31:0];
        e.c      = wide[32];
      end
      2'd2: begin
        e.result = b >> sh;
        if (sh != 5'd0) e.c = (((b >> (sh - 5'd1)) & 32'd1) != 32'd0);
      end
      default: begin
        e.result = 32'd0;
        e.err    = 1'b1;
      end
    endcase
    e.z = (e.result == 32'd0);
    e.n = e.result[31];
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] h, input logic [31:0] b,
                               input logic [4:0] sh, input logic ordy);
    entry_t e;
    e         = refEntry(h, b, sh);
    in_valid  = v;
    in_h      = h;
    in_b      = b;
    in_sh     = sh;
    in_result = (h == 2'd3) ? $urandom : e.result;
    out_ready = ordy;
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'(modelQ.size() > 0));
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'(modelReady));
    checkOutput({tag, "_err_count"}, 32'(err_count), 32'(modelErr));
    if (modelQ.size() > 0) begin
      checkOutput({tag, "_result"}, out_result, modelQ[0].result);
      checkOutput({tag, "_z"}, 32'(out_z), 32'(modelQ[0].z));
      checkOutput({tag, "_n"}, 32'(out_n), 32'(modelQ[0].n));
      checkOutput({tag, "_c"}, 32'(out_c), 32'(modelQ[0].c));
      checkOutput({tag, "_err"}, 32'(out_err), 32'(modelQ[0].err));
    end
  endtask

  // One clock: update the model from the pre-edge handshake, then check 1ns after the edge
  task automatic cycle(input string tag);
    bit     acc;
    bit     pp;
    entry_t e;
    acc = in_valid && modelReady;
    pp  = (modelQ.size() > 0) && out_ready;
    e   = refEntry(in_h, in_b, in_sh);
    @(posedge clk);
    if (pp) void'(modelQ.pop_front());
    if (acc) begin
      modelQ.push_back(e);
      if (e.err && modelErr < 255) modelErr++;
    end
    modelReady = (modelQ.size() != 2);
    #1;
    compareAll(tag);
  endtask

  task automatic doReset();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_result", out_result, 32'd0);
    checkOutput("rst_flags", 32'({out_z, out_n, out_c, out_err}), 32'd0);
    checkOutput("rst_err_count", 32'(err_count), 32'd0);
    modelQ.delete();
    modelReady = 1'b0;
    modelErr   = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hold_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    nAsserts   = 0;
    nFail      = 0;
    modelReady = 1'b0;
    modelErr   = 0;
    rst_n      = 1'b0;
    applyStimulus(1'b0, 2'd0, 32'd0, 5'd0, 1'b0);

    $display("[TB] reset");
    doReset();
    applyStimulus(1'b1, 2'd0, 32'h1234_5678, 5'd0, 1'b0);
    cycle("release");
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    checkOutput("release_no_accept", 32'(out_valid), 32'd0);

    $display("[TB] left shift carry");
    applyStimulus(1'b1, 2'd1, 32'h8000_0001, 5'd1, 1'b0);
    cycle("left");
    checkOutput("left_result", out_result, 32'h0000_0002);
    checkOutput("left_czn", 32'({out_c, out_z, out_n}), 32'b100);
    applyStimulus(1'b0, 2'd0, 32'd0, 5'd0, 1'b1);
    cycle("left_pop");

    $display("[TB] right shift and pass");
    applyStimulus(1'b1, 2'd2, 32'h0000_0001, 5'd1, 1'b1);
    cycle("right");
    checkOutput("right_zc", 32'({out_z, out_c}), 32'b11);
    applyStimulus(1'b1, 2'd0, 32'hFFFF_FFFF, 5'd7, 1'b1);
    cycle("pass");
    checkOutput("pass_c", 32'(out_c), 32'd0);
    applyStimulus(1'b0, 2'd0, 32'd0, 5'd0, 1'b1);
    cycle("drain0");

    $display("[TB] backpressure");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'd0, $urandom, 5'd0, 1'b0);
      cycle("bp");
      if (i == 1) checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    prevResult = out_result;
    applyStimulus(1'b1, 2'd1, $urandom, 5'd3, 1'b0);
    cycle("bp_hold");
    checkOutput("bp_stable", out_result, prevResult);

    $display("[TB] drain from full with in_valid");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'(i + 1), $urandom, 5'($urandom_range(0, 31)), 1'b1);
      cycle("drain_full");
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'd0, 32'd0, 5'd0, 1'b1);
      cycle("drain1");
    end

    $display("[TB] illegal opcodes");
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 2'd3, $urandom, 5'($urandom), 1'b1);
      cycle("illegal");
    end
    applyStimulus(1'b1, 2'd3, $urandom, 5'd0, 1'b1);
    cycle("illegal_sat");
    checkOutput("illegal_count_sat", 32'(err_count), 32'd255);
    checkOutput("illegal_result", out_result, 32'd0);
    checkOutput("illegal_err", 32'(out_err), 32'd1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom), 2'($urandom), $urandom, 5'($urandom), 1'($urandom));
      cycle("rand");
    end

    $display("[TB] reset while full");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'd3, $urandom, 5'd1, 1'b0);
      cycle("fill");
    end
    checkOutput("fill_full", 32'(in_ready), 32'd0);
    applyStimulus(1'b0, 2'd0, 32'd0, 5'd0, 1'b1);
    doReset();
    cycle("after_rst");
    checkOutput("after_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("after_rst_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
